iq_frame_fifo: RTL and testbench

//  Consumes the per-frame parallel I/R words and frame-ready pulse from the LVDS/ISERDES receiver.

---
 rtl/iq_frame_fifo.sv | 167 ++++++++++++++++
 tb/tb_iq_frame_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iq_frame_fifo.sv
// rtl/iq_frame_fifo.sv - LVDS frame capture, two's complement {I,R} packing, FWFT FIFO with drop stats.
// Optional build macro IQ_FIFO_TESTPAT_EN replaces captured samples with a frame counter pattern.
module iq_frame_fifo #(
  parameter int WORDWIDTH  = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int OFFSET_BIN = 1
) (
  input  logic                    i_lvds_dclk,
  input  logic                    i_rst,
  input  logic                    i_parFrameRdy,
  input  logic [WORDWIDTH-1:0]    i_dataIn_I,
  input  logic [WORDWIDTH-1:0]    i_dataIn_R,
  input  logic                    i_enable,
  input  logic                    i_clr_stats,
  input  logic                    i_rd_ready,
  output logic                    o_valid,
  output logic [2*WORDWIDTH-1:0]  o_data,
  output logic [DEPTH_LOG2:0]     o_level,
  output logic                    o_overflow,
  output logic [15:0]             o_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = 2 * WORDWIDTH;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [WORDWIDTH-1:0]  MSB_MASK   =
    (OFFSET_BIN != 0) ? {1'b1, {(WORDWIDTH-1){1'b0}}} : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   r_frm_q, r_frm_d_q;
  logic                   cap_pend_q, cap_pend_d;
  logic [DW-1:0]          cap_word_q, cap_word_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]          mem_q [DEPTH];

  logic strobe;
  logic capture_en;
  logic write_req;
  logic full;
  logic pop;
  logic wr_accept;
  logic drop;

  assign strobe = r_frm_q & ~r_frm_d_q;

  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    write_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_ARM;
      // Entering mid-pulse would capture a frame whose start was missed.
      ST_ARM:  if (!r_frm_q) state_d = ST_RUN;
      ST_RUN: begin
        capture_en = strobe;
        write_req  = cap_pend_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_enable) begin
      state_d    = ST_IDLE;
      capture_en = 1'b0;
      write_req  = 1'b0;
    end
  end

  assign cap_pend_d = capture_en;

`ifdef IQ_FIFO_TESTPAT_EN
  logic [WORDWIDTH-1:0] pat_cnt_q, pat_cnt_d;

  always_comb begin
    pat_cnt_d  = pat_cnt_q;
    cap_word_d = cap_word_q;
    if (capture_en) begin
      cap_word_d = {pat_cnt_q, ~pat_cnt_q};
      pat_cnt_d  = pat_cnt_q + WORDWIDTH'(1);
    end
  end

  always_ff @(posedge i_lvds_dclk or posedge i_rst) begin
    if (i_rst) pat_cnt_q <= '0;
    else       pat_cnt_q <= pat_cnt_d;
  end
`else
  always_comb begin
    cap_word_d = cap_word_q;
    if (capture_en) cap_word_d = {i_dataIn_I ^ MSB_MASK, i_dataIn_R ^ MSB_MASK};
  end
`endif

  assign full      = (level_q == FULL_LEVEL);
  assign o_valid   = (level_q != '0);
  assign pop       = o_valid & i_rd_ready;
  assign wr_accept = write_req & (~full | pop);
  assign drop      = write_req & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_accept && !pop)      level_d = level_q + LEVEL_ONE;
    else if (!wr_accept && pop) level_d = level_q - LEVEL_ONE;
    if (i_clr_stats) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop on the clearing edge is still reported.
    if (drop) begin
      overflow_d = 1'b1;
      if (i_clr_stats)                drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_lvds_dclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      r_frm_q    <= 1'b0;
      r_frm_d_q  <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_word_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      r_frm_q    <= i_parFrameRdy;
      r_frm_d_q  <= r_frm_q;
      cap_pend_q <= cap_pend_d;
      cap_word_q <= cap_word_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge i_lvds_dclk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= cap_word_q;
  end

  assign o_data       = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_level      = level_q;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_iq_frame_fifo.sv
// tb/tb_iq_frame_fifo.sv - directed self-checking bench for iq_frame_fifo.
// Build with IQ_FIFO_TESTPAT_EN defined to run the counter-pattern sequence instead.
module tb_iq_frame_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        frm;
  logic [11:0] din_i, din_r;
  logic        enable, clr_stats, rd_ready;
  logic        valid;
  logic [23:0] data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  iq_frame_fifo dut (
    .i_lvds_dclk   (clk),
    .i_rst         (rst),
    .i_parFrameRdy (frm),
    .i_dataIn_I    (din_i),
    .i_dataIn_R    (din_r),
    .i_enable      (enable),
    .i_clr_stats   (clr_stats),
    .i_rd_ready    (rd_ready),
    .o_valid       (valid),
    .o_data        (data),
    .o_level       (level),
    .o_overflow    (overflow),
    .o_drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two-cycle frame pulse followed by two quiet cycles, so the write has landed on return.
  task automatic send_frame(input logic [11:0] i_s, input logic [11:0] r_s);
    din_i = i_s;
    din_r = r_s;
    frm   = 1'b1;
    idle(2);
    frm   = 1'b0;
    idle(2);
  endtask

  task automatic pop_check(input logic [23:0] exp, input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, 32'(data), 32'(exp));
    rd_ready = 1'b1;
    idle(1);
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frm = 1'b0; din_i = '0; din_r = '0;
    enable = 1'b0; clr_stats = 1'b0; rd_ready = 1'b0;
    idle(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(3);

`ifdef IQ_FIFO_TESTPAT_EN
    for (int n = 0; n < 5; n++) send_frame(12'h123, 12'h456);
    chk("tp_level", 32'(level), 32'd5);
    for (int n = 0; n < 5; n++) begin
      logic [11:0] c;
      c = 12'(n);
      pop_check({c, ~c}, "tp_word");
    end
    chk("tp_empty", 32'(valid), 32'd0);
`else
    // Conversion and packing
    send_frame(12'h800, 12'h000);
    send_frame(12'hFFF, 12'h7FF);
    send_frame(12'h001, 12'h801);
    chk("t1_level", 32'(level), 32'd3);
    pop_check(24'h000_800, "t1_w0");
    pop_check(24'h7FF_FFF, "t1_w1");
    pop_check(24'h801_001, "t1_w2");
    chk("t1_empty", 32'(valid), 32'd0);

    // Overflow: 20 frames into 16 entries
    for (int n = 0; n < 20; n++) send_frame(12'h800 | 12'(n), 12'h800);
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_count), 32'd4);
    for (int n = 0; n < 16; n++) pop_check({12'(n), 12'h000}, "t2_drain");
    chk("t2_empty", 32'(valid), 32'd0);
    chk("t2_level0", 32'(level), 32'd0);

    // Full with simultaneous write and pop, then clear and clear-vs-drop
    for (int n = 0; n < 16; n++) send_frame(12'h800 | 12'(n), 12'h800);
    chk("t3_full", 32'(level), 32'd16);
    din_i = 12'h8AB; din_r = 12'h800; frm = 1'b1;
    idle(2);
    frm = 1'b0;
    rd_ready = 1'b1;
    idle(1);
    rd_ready = 1'b0;
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_drop", 32'(drop_count), 32'd4);
    chk("t3_head", 32'(data), 32'h001_000);
    idle(1);
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_drop", 32'(drop_count), 32'd0);
    din_i = 12'h8CD; frm = 1'b1;
    idle(2);
    frm = 1'b0;
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    chk("t3_cd_ovf", 32'(overflow), 32'd1);
    chk("t3_cd_drop", 32'(drop_count), 32'd1);
    chk("t3_cd_level", 32'(level), 32'd16);
    idle(1);
    for (int n = 1; n < 16; n++) pop_check({12'(n), 12'h000}, "t3_drain");
    pop_check(24'h0AB_000, "t3_tail");
    chk("t3_empty", 32'(valid), 32'd0);

    // Enable raised during a pulse: that pulse is ignored
    enable = 1'b0;
    idle(2);
    din_i = 12'h811; din_r = 12'h822; frm = 1'b1;
    idle(1);
    enable = 1'b1;
    idle(1);
    frm = 1'b0;
    idle(4);
    chk("t4_ignored", 32'(level), 32'd0);
    send_frame(12'h833, 12'h844);
    chk("t4_level", 32'(level), 32'd1);
    pop_check(24'h033_044, "t4_next");
    // Enable removed with a capture in flight
    din_i = 12'h855; frm = 1'b1;
    idle(2);
    enable = 1'b0;
    frm = 1'b0;
    idle(3);
    chk("t4_discard", 32'(level), 32'd0);

    // Asynchronous reset with 7 entries
    enable = 1'b1;
    idle(3);
    for (int n = 0; n < 7; n++) send_frame(12'h900 | 12'(n), 12'h800);
    chk("t5_level7", 32'(level), 32'd7);
    chk("t5_drop_pre", 32'(drop_count), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    din_i = 12'h866; frm = 1'b1;
    idle(2);
    frm = 1'b0;
    idle(4);
    chk("t5_armed", 32'(level), 32'd0);
    send_frame(12'h877, 12'h888);
    chk("t5_resume", 32'(level), 32'd1);
    pop_check(24'h077_088, "t5_word");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
